// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared state encoding and two's-complement helpers for div_seq
package div_seq_pkg;

  // Widest operand the helpers support; callers cast in and out at their own width.
  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  // Two's-complement negate, ~x + 1 modulo 2^MAX_W.
  function automatic logic [MAX_W-1:0] twos_neg(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

  // Magnitude of a value whose sign bit is passed separately.
  function automatic logic [MAX_W-1:0] twos_abs(input logic [MAX_W-1:0] x, input logic neg);
    return neg ? twos_neg(x) : x;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - start/done handshake and result bus for div_seq
interface div_seq_if #(parameter int N = 4);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;
  logic         overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one unsigned restoring-division step
module div_restore_step #(
  parameter int N = 4
) (
  input  logic [N:0]   r_i,
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] d_i,
  output logic [N:0]   r_o,
  output logic [N-1:0] q_o
);

  logic [N:0] r_sh;
  logic       ge;

  // Shift the next dividend bit into R and subtract the divisor when it fits.
  // R[N] set would mean the shifted value already exceeds any N-bit divisor.
  always_comb begin
    r_sh = {r_i[N-1:0], q_i[N-1]};
    ge   = r_i[N] | (r_sh >= {1'b0, d_i});
    r_o  = ge ? (r_sh - {1'b0, d_i}) : r_sh;
    q_o  = {q_i[N-2:0], ge};
  end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential signed sign-magnitude restoring divider
module div_seq
  import div_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam int CW = $clog2(N + 1);

  state_e         state_q, state_d;
  logic [N:0]     r_q, r_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [N-1:0]   dvd_q, dvd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic           dz_pend_q, dz_pend_d;
  logic           ov_pend_q, ov_pend_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dz_q, dz_d;
  logic           ov_q, ov_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [N:0]     r_step;
  logic [N-1:0]   q_step;

  div_restore_step #(.N(N)) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (dvs_q),
    .r_o (r_step),
    .q_o (q_step)
  );

  // Next-state and datapath: accept in IDLE, iterate N steps in CALC, sign-fix in FIX.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    q_d       = q_q;
    dvs_d     = dvs_q;
    dvd_d     = dvd_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_pend_d = dz_pend_q;
    ov_pend_d = ov_pend_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    ov_d      = ov_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          neg_quo_d = bus.dividend[N-1] ^ bus.divisor[N-1];
          neg_rem_d = bus.dividend[N-1];
          q_d       = N'(twos_abs(MAX_W'(bus.dividend), bus.dividend[N-1]));
          dvs_d     = N'(twos_abs(MAX_W'(bus.divisor), bus.divisor[N-1]));
          dvd_d     = bus.dividend;
          r_d       = '0;
          cnt_d     = CW'(N);
          dz_pend_d = (bus.divisor == '0);
          ov_pend_d = (bus.dividend == {1'b1, {(N-1){1'b0}}}) && (bus.divisor == {N{1'b1}});
          busy_d    = 1'b1;
          state_d   = CALC;
        end
      end
      CALC: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (dz_pend_q) begin
          quo_d = {N{1'b1}};
          rem_d = dvd_q;
        end else if (ov_pend_q) begin
          quo_d = {1'b1, {(N-1){1'b0}}};
          rem_d = '0;
        end else begin
          quo_d = neg_quo_q ? N'(twos_neg(MAX_W'(q_q))) : q_q;
          rem_d = neg_rem_q ? N'(twos_neg(MAX_W'(r_q[N-1:0]))) : r_q[N-1:0];
        end
        dz_d    = dz_pend_q;
        ov_d    = ov_pend_q & ~dz_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and all registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      r_q       <= '0;
      q_q       <= '0;
      dvs_q     <= '0;
      dvd_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_pend_q <= 1'b0;
      ov_pend_q <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
      ov_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      q_q       <= q_d;
      dvs_q     <= dvs_d;
      dvd_q     <= dvd_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_pend_q <= dz_pend_d;
      ov_pend_q <= ov_pend_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
      ov_q      <= ov_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
  assign bus.overflow  = ov_q;

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential signed two's-complement divider; the inverse of the team's combinational signed multiplier.
- Uses the same sign-magnitude scheme as the multiplier: take magnitudes, run an unsigned restoring divide one bit per clock, then re-apply signs.
- Sits beside the multiplier in the arith/twocomplement library.
- Start/done handshake; results are held until the next operation completes.

Parameters:
- N, 4, operand width in bits for dividend, divisor, quotient and remainder (N >= 2).

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a divide; sampled only in IDLE.
- dividend  input  N  signed dividend; captured on the accepting edge.
- divisor  input  N  signed divisor; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- quotient  output  N  signed quotient, truncated toward zero.
- remainder  output  N  signed remainder; its sign follows the dividend.
- div_zero  output  1  last operation had divisor == 0.
- overflow  output  1  last operation was -2^(N-1) / -1.

Behaviour:
- Reset (async, rst=1): state IDLE; busy=0, done=0; quotient, remainder, div_zero and overflow all 0; internal registers cleared. Reset mid-operation aborts the operation and no done is produced.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 on edge E0: capture sign_q = msb(dividend) ^ msb(divisor) and sign_r = msb(dividend).
  - Load unsigned N-bit magnitudes; |-2^(N-1)| = 2^(N-1) fits unsigned.
  - Clear partial remainder R (N+1 bits). Set step counter to N. Go to CALC; busy=1 from E0.
- CALC, one restoring step per edge:
  - R' = {R[N-1:0], Qmsb}; shift Q left by 1.
  - If R' >= |divisor|: R = R' - |divisor| and Q[0] = 1; else R = R' and Q[0] = 0.
  - Decrement the counter. After the N-th step go to FIX.
  - A divisor of 0 still runs N steps; the datapath result is discarded.
- FIX, one edge:
  - Normal case: quotient = sign_q ? -Q : Q; remainder = sign_r ? -R[N-1:0] : R[N-1:0].
  - div_zero case: quotient = all ones; remainder = dividend as captured; div_zero=1; overflow=0.
  - overflow case (dividend = 100..0, divisor = 11..1): quotient = 100..0 (the natural wrap); remainder = 0; overflow=1.
  - Otherwise div_zero=0 and overflow=0.
  - Set done=1 and busy=0; return to IDLE.
- Latency:
  - done is high exactly one cycle, N+2 edges after E0 (E0 + N CALC edges + 1 FIX edge).
  - busy is high for the N+1 cycles before done.
  - Latency is identical for div_zero and overflow.
- Handshake:
  - start while busy is ignored; operands are not re-sampled.
  - start in the done cycle is accepted (state is IDLE). Outputs keep their values until that operation's FIX edge.
- Outputs change only on the FIX edge or on reset; they are stable between operations.
- Width rules:
  - Negation is ~x+1 modulo 2^N.
  - The compare/subtract uses N+1 bits so no carry is lost.

Decomposition:
- Shared package/header:
  - State encoding constants (IDLE=2'd0, CALC=2'd1, FIX=2'd2).
  - Two's-complement abs/negate function, shared with the multiplier.
- One sub-module, div_restore_step, purely combinational:
  - Inputs: R, Q, |divisor|.
  - Outputs: next R and next Q.
  - Instantiated once and iterated by the CALC state.

Test Plan (N=4):
- 7/2 (0111/0010): quotient=0011, remainder=0001, flags 0. done is high exactly 6 edges after start and for one cycle; busy is high the 5 cycles before.
- -7/2 (1001/0010): quotient=1101 (-3), remainder=1111 (-1). 7/-2: quotient=1101, remainder=0001. -7/-2: quotient=0011, remainder=1111.
- -8/-1 (1000/1111): quotient=1000, remainder=0000, overflow=1, div_zero=0. -8/1: quotient=1000, remainder=0000, overflow=0.
- 5/0: quotient=1111, remainder=0101, div_zero=1, done on edge 6. A following 6/3 gives quotient=0010, remainder=0000 and clears div_zero.
- Handshake: start pulsed mid-CALC with new operands is ignored and the original result is delivered. start held high during the done cycle begins the next divide immediately.
- Reset: rst asserted asynchronously mid-CALC forces busy=0, done=0 and all outputs 0 immediately. No done follows. A fresh start after release completes normally.
